// File: rtl/mont_pkg.sv
// Shared types and constants for the Montgomery squaring sequencer and the
// multi-mode multiplier it drives.
package mont_pkg;

  localparam int DEF_NUM_ELEMENTS = 33;
  localparam int DEF_DSP_BIT_LEN  = 17;
  localparam int DEF_WORD_LEN     = 16;

  localparam logic [2:0] CTL_NONE = 3'b000;
  localparam logic [2:0] CTL_SQ   = 3'b001;
  localparam logic [2:0] CTL_LO   = 3'b010;
  localparam logic [2:0] CTL_HI   = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SQ,
    ST_LO,
    ST_HI,
    ST_UPD,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/mont_sqr_sequencer.sv
// Sequences square / lower-half / upper-half multiplier passes for repeated
// Montgomery squaring and hands the final residue back over valid/ready.
module mont_sqr_sequencer
  import mont_pkg::*;
#(
  parameter int NUM_ELEMENTS = DEF_NUM_ELEMENTS,
  parameter int DSP_BIT_LEN  = DEF_DSP_BIT_LEN,
  parameter int ITER_W       = 64
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic                                   i_start,
  output logic                                   o_ready,
  input  logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]    i_x,
  input  logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]    i_mod,
  input  logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]    i_minv,
  input  logic [ITER_W-1:0]                      i_iters,
  output logic [2:0]                             o_ctl,
  output logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]    o_mul_a,
  output logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]    o_mul_b,
  output logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]    o_add_term,
  input  logic [2*NUM_ELEMENTS*DSP_BIT_LEN-1:0]  i_mul_dat,
  output logic                                   o_valid,
  input  logic                                   i_ready,
  output logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]    o_x,
  output logic [ITER_W-1:0]                      o_iter_left
);

  localparam int W = NUM_ELEMENTS * DSP_BIT_LEN;

  seq_state_t state, state_nxt;

  logic [W-1:0]      x_reg, mod_reg, minv_reg, thi_reg;
  logic [ITER_W-1:0] cnt;

  logic [W-1:0] mul_lo, mul_hi, mul_lo_rev, thi_rev;

  assign mul_lo = i_mul_dat[W-1:0];
  assign mul_hi = i_mul_dat[2*W-1:W];

  // The multiplier consumes its add term and emits its upper-mode result
  // with element order reversed relative to our registers.
  for (genvar i = 0; i < NUM_ELEMENTS; i++) begin : g_rev
    assign mul_lo_rev[i*DSP_BIT_LEN +: DSP_BIT_LEN] = mul_lo[(NUM_ELEMENTS-1-i)*DSP_BIT_LEN +: DSP_BIT_LEN];
    assign thi_rev[i*DSP_BIT_LEN +: DSP_BIT_LEN]    = thi_reg[(NUM_ELEMENTS-1-i)*DSP_BIT_LEN +: DSP_BIT_LEN];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_reg    <= '0;
      mod_reg  <= '0;
      minv_reg <= '0;
      thi_reg  <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            x_reg    <= i_x;
            mod_reg  <= i_mod;
            minv_reg <= i_minv;
            cnt      <= i_iters;
          end
        end
        ST_LO:   thi_reg <= mul_hi;
        ST_UPD: begin
          x_reg <= mul_lo_rev;
          cnt   <= cnt - ITER_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    o_ctl      = CTL_NONE;
    o_mul_a    = '0;
    o_mul_b    = '0;
    o_add_term = '0;
    case (state)
      ST_IDLE: begin
        if (i_start) state_nxt = (i_iters == '0) ? ST_DONE : ST_SQ;
      end
      ST_SQ: begin
        o_ctl     = CTL_SQ;
        o_mul_a   = x_reg;
        o_mul_b   = x_reg;
        state_nxt = ST_LO;
      end
      ST_LO: begin
        o_ctl     = CTL_LO;
        o_mul_a   = mul_lo;
        o_mul_b   = minv_reg;
        state_nxt = ST_HI;
      end
      ST_HI: begin
        o_ctl      = CTL_HI;
        o_mul_a    = mul_lo;
        o_mul_b    = mod_reg;
        o_add_term = thi_rev;
        state_nxt  = ST_UPD;
      end
      ST_UPD: begin
        state_nxt = (cnt == ITER_W'(1)) ? ST_DONE : ST_SQ;
      end
      ST_DONE: begin
        if (i_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign o_ready     = (state == ST_IDLE);
  assign o_valid     = (state == ST_DONE);
  assign o_x         = x_reg;
  assign o_iter_left = cnt;

endmodule

// File: doc/mont_sqr_sequencer.md
# mont_sqr_sequencer

Controller that drives the shared multi-mode multiplier through repeated Montgomery squarings for the VDF evaluation loop. Per iteration it issues three multiplier passes in a fixed order: square, lower-half multiply by M', then upper-half multiply by M with accumulation. It feeds the result back as the next operand and counts down the iteration budget. It sits between the host-side load/unload logic and the multiplier, owns the multiplier's mode select and operand/add-term muxing, and returns the final residue through a valid/ready handshake.

## Interface
- NUM_ELEMENTS, 33, redundant words per operand
- DSP_BIT_LEN, 17, bits per redundant word
- WORD_LEN, 16, non-redundant word width (carry boundary)
- ITER_W, 64, iteration counter width
- i_clk  in  1  clock
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_start  in  1  start request, sampled only in IDLE
- o_ready  out  1  high in IDLE (start accepted when i_start & o_ready)
- i_x  in  NUM_ELEMENTS×DSP_BIT_LEN  initial value (Montgomery form)
- i_mod  in  NUM_ELEMENTS×DSP_BIT_LEN  modulus M, latched at start
- i_minv  in  NUM_ELEMENTS×DSP_BIT_LEN  M' = −M⁻¹ mod R, latched at start
- i_iters  in  ITER_W  number of squarings, latched at start
- o_ctl  out  3  one-hot multiplier mode: [0] square, [1] lower, [2] upper; 000 when idle
- o_mul_a, o_mul_b, o_add_term  out  NUM_ELEMENTS×DSP_BIT_LEN  multiplier operands
- i_mul_dat  in  2·NUM_ELEMENTS×DSP_BIT_LEN  registered multiplier output (1-cycle latency)
- o_valid  out  1  final result available
- i_ready  in  1  consumer accepts result
- o_x  out  NUM_ELEMENTS×DSP_BIT_LEN  final residue (x_reg)
- o_iter_left  out  ITER_W  remaining iterations (debug/progress)

## Operation
- States: IDLE, SQ, LO, HI, UPD, DONE.
- IDLE: o_ready=1, o_ctl=000. On i_start: latch x_reg←i_x, mod_reg, minv_reg, cnt←i_iters; go to SQ, or to DONE if i_iters==0.
- SQ: o_ctl=001, a=b=x_reg, add_term=0.
- LO: o_ctl=010, a=i_mul_dat[0..N−1] (T low), b=minv_reg, add_term=0; capture thi_reg←i_mul_dat[N..2N−1].
- HI: o_ctl=100, a=i_mul_dat[0..N−1] (m), b=mod_reg, o_add_term[i]=thi_reg[N−1−i] (element-reversed, matching the multiplier's add-term ordering).
- UPD: o_ctl=000; x_reg[i]←i_mul_dat[N−1−i]; cnt←cnt−1; go to DONE if cnt==1, else to SQ.
- DONE: o_valid=1, o_x=x_reg stable; on i_ready go to IDLE. Result is held indefinitely without i_ready.
- i_start is ignored outside IDLE. Input changes after acceptance have no effect.
- o_ctl is always one-hot or zero; never multi-hot.
- Operand outputs are 0 in IDLE, UPD, and DONE.

## Timing
- Reset: state=IDLE, o_ctl=000, o_valid=0, o_ready=1, x_reg/thi_reg/mod_reg/minv_reg=0, cnt=0. All operand outputs are 0.
- Reset mid-operation aborts immediately. The partial result is discarded and o_valid drops asynchronously.
- 4 cycles per iteration. With the start accepted at edge 0, o_valid rises in cycle 4·iters+1.
- i_iters=0: o_valid in cycle 1, and o_x=i_x.
- Result accept and new start: DONE→IDLE on the i_ready edge, so a new start is accepted no earlier than the following edge. Minimum 1 idle cycle between jobs.
- i_mul_dat is sampled only in LO, HI, and UPD. It is ignored in all other states.

## Structure
- Shared package mont_pkg holds:
  - state enum `seq_state_t`
  - mode constants CTL_SQ=3'b001, CTL_LO=3'b010, CTL_HI=3'b100
  - the default NUM_ELEMENTS, DSP_BIT_LEN, and WORD_LEN
- No sub-module: the FSM, the counter, and the operand muxes live in one module. The multiplier is instantiated by the parent, not inside this block.

## Test plan
- Reset: hold i_rst_n=0 → o_ctl=000, o_valid=0, o_ready=1. Release it and i_start=0 → stays IDLE.
- i_iters=0, i_x=0x1234 (word 0) → o_valid in cycle 1, o_x equals i_x, o_ctl never leaves 000.
- i_iters=3 with a bench multiplier model → o_ctl sequence 001,010,100,000 repeated 3×. o_valid in cycle 13, and o_x matches the reference Montgomery model of x^(2^3)·R^(−7).
- Montgomery one: i_x = R mod M, i_iters=5 → o_x ≡ R mod M after normalization.
- Backpressure: i_ready=0 for 10 cycles in DONE → o_valid and o_x are stable and i_start is ignored. i_ready=1 → IDLE next cycle.
- Async reset asserted during HI of iteration 2 → outputs return to reset values without a clock edge. A new start with i_iters=1 completes in 5 cycles.
